dac_stream_buffer: RTL and testbench
====================================

# dac_stream_buffer

Elastic buffer between the transmit datapath's 256-bit DAC stream and the RF data converter DAC AXI4-Stream port. Absorbs tready gaps upstream, holds off output until a programmable prefill level is reached, then streams continuously. Substitutes zero words on underflow so the DAC never sees stale data. Reports fill level and underflow status to the debug/control register space.

## Interface
- DATA_WIDTH, 256, stream word width (16 samples × 16 bit)
- ADDR_WIDTH, 4, log2 of FIFO depth (DEPTH = 16)
- PREFILL, 8, level at which PREFILL transitions to RUN; legal range 1..DEPTH

- clock  in  1  stream clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  level-sensitive run enable from control registers
- clear  in  1  single-cycle pulse; clears sticky underflow (and counter when compiled in)
- s_tvalid  in  1  upstream word valid
- s_tdata  in  DATA_WIDTH  upstream word
- s_tready  out  1  buffer can accept
- m_tready  in  1  DAC port ready
- m_tdata  out  DATA_WIDTH  registered output word
- m_tvalid  out  1  output valid
- level  out  ADDR_WIDTH+1  current FIFO occupancy, 0..DEPTH
- underflow  out  1  sticky underflow flag
- underflow_count  out  16  underflow word count (only with macro, see Configuration)

## Operation
- Storage: DEPTH-entry circular RAM, read/write pointers ADDR_WIDTH bits wrapping modulo DEPTH; level tracked separately.
- Push: s_tvalid && s_tready. s_tready = (state != IDLE) && (level < DEPTH).
- States:
  - IDLE: m_tvalid=0, m_tdata=0, s_tready=0, pointers and level held at 0. enable=1 → PREFILL.
  - PREFILL: m_tvalid=1, m_tdata loaded with 0 on every m_tready edge, no pops. level >= PREFILL → RUN.
  - RUN: m_tvalid=1. On every edge with m_tready=1: if level>0, m_tdata <= head word, pop; else m_tdata <= 0, set underflow, increment counter, next state PREFILL.
  - Any state: enable=0 → IDLE next edge; FIFO flushed (pointers, level to 0), m_tdata to 0. underflow/counter are not cleared by enable.
- m_tready=0 in RUN: no pop, m_tdata holds.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Full (level == DEPTH): s_tready=0; push attempts ignored.
- clear concurrent with new underflow: set wins (flag stays 1, counter = 1 after clear-then-increment).
- underflow_count saturates at 16'hFFFF.

## Timing
- Reset: state IDLE; m_tvalid=0, m_tdata=0, s_tready=0, level=0, underflow=0, underflow_count=0.
- Push at edge N: level reflects it after edge N.
- Pop: head word appears on m_tdata after the m_tready edge; one-cycle registered output latency.
- PREFILL→RUN: transition on the edge after level first reaches PREFILL; first data word is on m_tdata one m_tready edge later.
- Throughput: one word per cycle in RUN with s_tvalid=m_tready=1 continuously.
- enable deassert: state IDLE and m_tvalid=0 after one edge; words in flight discarded.

## Configuration
- DAC_UNDERFLOW_CNT_EN defined: 16-bit saturating underflow_count implemented, cleared by reset and clear.
- Undefined: underflow_count tied to 0; only the sticky underflow flag exists.

## Test plan
- Reset, enable=1, push 8 words 1..8 with m_tready=1 → m_tvalid=1 with zeros during PREFILL, RUN entered, m_tdata emits 1..8 in order, then zero word, underflow=1, count=1, state PREFILL.
- Push 16 words with m_tready=0 → level=16, s_tready=0, 17th word not accepted, then m_tready=1 → exactly words 1..16 out.
- Continuous s_tvalid=m_tready=1 after prefill for 1000 cycles → level constant at PREFILL, no underflow, data sequence intact across pointer wrap.
- Deassert enable mid-RUN with level=5 → next edge m_tvalid=0, level=0, m_tdata=0; reassert → fresh prefill, no old words emitted.
- Force underflow and pulse clear on the same edge → underflow=1, count=1; clear alone next cycle → underflow=0, count=0.
- Assert resetn low mid-RUN asynchronously → outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/dac_stream_buffer.sv
// rtl/dac_stream_buffer.sv - elastic DAC stream FIFO with prefill, zero-fill on underflow; optional counter via DAC_UNDERFLOW_CNT_EN
module dac_stream_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 4,
  parameter int PREFILL    = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  s_tvalid,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  s_tready,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  underflow,
  output logic [15:0]           underflow_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   PREFILL_L = (ADDR_WIDTH+1)'(PREFILL);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic                    push;
  logic                    pop;
  logic                    underrun;

  // Accept only while active and not full; enable low flushes, so no push then.
  assign s_tready = (state != ST_IDLE) && (level < DEPTH_L);
  assign push     = enable && s_tvalid && s_tready;
  assign pop      = enable && (state == ST_RUN) && m_tready && (level != '0);
  assign underrun = enable && (state == ST_RUN) && m_tready && (level == '0);

  // Storage array: written on every accepted push, not reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

  // Control FSM with pointer/level bookkeeping and the registered output word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
    end else if (!enable) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      case (state)
        ST_IDLE: begin
          state    <= ST_PREFILL;
          m_tvalid <= 1'b1;
        end
        ST_PREFILL: begin
          if (m_tready) m_tdata <= '0;
          if (level >= PREFILL_L) state <= ST_RUN;
        end
        ST_RUN: begin
          if (m_tready) begin
            if (level != '0) begin
              m_tdata <= mem[rd_ptr];
            end else begin
              m_tdata <= '0;
              state   <= ST_PREFILL;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          m_tvalid <= 1'b0;
        end
      endcase
    end
  end

  // Sticky underflow flag: a new underrun wins over a concurrent clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       underflow <= 1'b0;
    else if (underrun) underflow <= 1'b1;
    else if (clear)    underflow <= 1'b0;
  end

`ifdef DAC_UNDERFLOW_CNT_EN
  // Saturating underrun counter; clear then increment when both happen together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      underflow_count <= 16'd0;
    end else if (clear) begin
      underflow_count <= underrun ? 16'd1 : 16'd0;
    end else if (underrun && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end
`else
  assign underflow_count = 16'd0;
`endif

endmodule

// File: tb/tb_dac_stream_buffer.sv
// tb/tb_dac_stream_buffer.sv - randomized self-checking bench for dac_stream_buffer against a queue model
module tb_dac_stream_buffer;
  localparam int DW    = 256;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PF    = 8;
`ifdef DAC_UNDERFLOW_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tready;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic [AW:0]   level;
  logic          underflow;
  logic [15:0]   underflow_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dac_stream_buffer dut (
    .clock(clock), .resetn(resetn), .enable(enable), .clear(clear),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
    .m_tready(m_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .level(level), .underflow(underflow), .underflow_count(underflow_count)
  );

  // Reference model: queue of buffered words, mode 0 idle / 1 prefill / 2 run
  logic [DW-1:0] q[$];
  int            st;
  logic [DW-1:0] e_data;
  bit            e_valid;
  bit            e_uf;
  int            e_cnt;
  logic [DW-1:0] got[$];
  logic [DW-1:0] words[$];

  function automatic bit e_ready();
    return (st != 0) && (q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    q.delete(); st = 0; e_data = '0; e_valid = 0; e_uf = 0; e_cnt = 0;
  endtask

  task automatic model_edge();
    bit push;
    bit nu;
    nu = 0;
    push = s_tvalid && e_ready();
    if (!enable) begin
      q.delete(); st = 0; e_data = '0; e_valid = 0;
    end else begin
      if (st == 0) begin
        st = 1; e_valid = 1;
      end else if (st == 1) begin
        if (m_tready) e_data = '0;
        if (q.size() >= PF) st = 2;
      end else if (m_tready) begin
        if (q.size() > 0) e_data = q.pop_front();
        else begin e_data = '0; nu = 1; st = 1; end
      end
      if (push) q.push_back(s_tdata);
    end
    if (nu) begin
      e_uf = 1;
      if (CNT_EN) e_cnt = clear ? 1 : ((e_cnt < 65535) ? e_cnt + 1 : e_cnt);
    end else if (clear) begin
      e_uf = 0; e_cnt = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 0; model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %0b want 0", m_tvalid); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_m_tdata got %0h want 0", m_tdata); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %0b want 0", s_tready); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %0b want 0", underflow); end
    checks++; if (underflow_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", underflow_count); end
    resetn = 1;
    #2;
  endtask

  task automatic test_prefill_run();
    int n;
    n = 1; got.delete();
    enable = 1; m_tready = 1;
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== '0) begin errors++; $display("FAIL prefill_out got v=%0b d=%0h want v=1 d=0", m_tvalid, m_tdata); end
    for (int i = 0; i < 20; i++) begin
      s_tvalid = (n <= 8); s_tdata = DW'(n);
      if (s_tvalid && e_ready()) n++;
      tick();
      if (m_tdata !== '0) got.push_back(m_tdata);
      checks++; if (m_tdata !== e_data) begin errors++; $display("FAIL prefill_model_data got %0h want %0h", m_tdata, e_data); end
    end
    s_tvalid = 0;
    checks++; if (got.size() != 8) begin errors++; $display("FAIL prefill_count_out got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== DW'(i + 1)) begin errors++; $display("FAIL prefill_order[%0d] got %0h want %0h", i, got[i], i + 1); end
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL prefill_underflow got %0b want 1", underflow); end
    checks++; if (underflow_count !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL prefill_ucount got %0d want %0d", underflow_count, CNT_EN ? 1 : 0); end
    checks++; if (m_tvalid !== 1'b1 || level !== '0) begin errors++; $display("FAIL prefill_after_uf got v=%0b lvl=%0d want v=1 lvl=0", m_tvalid, level); end
  endtask

  task automatic test_full();
    enable = 0; tick();
    enable = 1; m_tready = 0; tick();
    words.delete(); got.delete();
    for (int i = 0; i < 17; i++) begin
      s_tdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} | DW'(1);
      s_tvalid = 1;
      if (i == 16) begin
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL full_s_tready got %0b want 0", s_tready); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", level); end
      end
      if (i < 16) words.push_back(s_tdata);
      tick();
    end
    s_tvalid = 0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level_after17 got %0d want 16", level); end
    m_tready = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_tdata !== '0) got.push_back(m_tdata);
    end
    checks++; if (got.size() != 16) begin errors++; $display("FAIL full_out_count got %0d want 16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      checks++; if (got[i] !== words[i]) begin errors++; $display("FAIL full_word[%0d] got %0h want %0h", i, got[i], words[i]); end
    end
  endtask

  task automatic test_stream();
    int n;
    int expo;
    bit acc;
    n = 1; expo = 1;
    enable = 0; clear = 1; tick(); clear = 0;
    enable = 1; m_tready = 1;
    for (int i = 0; i < 30 && st != 2; i++) begin
      s_tvalid = (st != 0) && !(st == 1 && q.size() >= PF);
      s_tdata = DW'(n);
      acc = s_tvalid && e_ready();
      tick();
      if (acc) n++;
    end
    checks++; if (level !== 5'(PF)) begin errors++; $display("FAIL stream_start_level got %0d want %0d", level, PF); end
    for (int i = 0; i < 1000; i++) begin
      s_tvalid = 1; s_tdata = DW'(n);
      tick(); n++;
      checks++; if (level !== 5'(PF)) begin errors++; $display("FAIL stream_level cyc %0d got %0d want %0d", i, level, PF); end
      checks++; if (m_tdata !== DW'(expo)) begin errors++; $display("FAIL stream_data cyc %0d got %0h want %0h", i, m_tdata, expo); end
      expo++;
    end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow got %0b want 0", underflow); end
  endtask

  task automatic test_enable_drop();
    int n;
    bit acc;
    s_tvalid = 0;
    repeat (3) tick();
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL drop_level_pre got %0d want 5", level); end
    enable = 0; tick();
    checks++; if (m_tvalid !== 1'b0 || level !== '0 || m_tdata !== '0 || s_tready !== 1'b0)
      begin errors++; $display("FAIL drop_flush got v=%0b lvl=%0d d=%0h rdy=%0b want 0 0 0 0", m_tvalid, level, m_tdata, s_tready); end
    enable = 1; n = 0; got.delete();
    for (int i = 0; i < 25; i++) begin
      s_tvalid = (n < 8); s_tdata = DW'(32'hA500_0000 + n);
      acc = s_tvalid && e_ready();
      tick();
      if (acc) n++;
      if (m_tdata !== '0) got.push_back(m_tdata);
    end
    s_tvalid = 0;
    checks++; if (got.size() != 8) begin errors++; $display("FAIL drop_out_count got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++; if (got[i] !== DW'(32'hA500_0000 + i)) begin errors++; $display("FAIL drop_word[%0d] got %0h want %0h", i, got[i], 32'hA500_0000 + i); end
    end
  endtask

  task automatic test_underflow_clear();
    int n;
    bit acc;
    n = 0; m_tready = 1;
    for (int i = 0; i < 40 && !(st == 2 && q.size() == 0); i++) begin
      s_tvalid = (n < 8); s_tdata = DW'(n + 100);
      acc = s_tvalid && e_ready();
      tick();
      if (acc) n++;
    end
    s_tvalid = 0;
    clear = 1; tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clr_set_wins_flag got %0b want 1", underflow); end
    checks++; if (underflow_count !== (CNT_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL clr_set_wins_count got %0d want %0d", underflow_count, CNT_EN ? 1 : 0); end
    tick();
    clear = 0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clr_alone_flag got %0b want 0", underflow); end
    checks++; if (underflow_count !== 16'd0) begin errors++; $display("FAIL clr_alone_count got %0d want 0", underflow_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 99) != 0);
      clear    = ($urandom_range(0, 29) == 0);
      s_tvalid = ($urandom_range(0, 9) < 6);
      m_tready = ($urandom_range(0, 9) < 5);
      s_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      checks++; if (s_tready !== e_ready()) begin errors++; $display("FAIL rnd_s_tready cyc %0d got %0b want %0b", i, s_tready, e_ready()); end
      tick();
      checks++; if (m_tdata !== e_data) begin errors++; $display("FAIL rnd_m_tdata cyc %0d got %0h want %0h", i, m_tdata, e_data); end
      checks++; if (m_tvalid !== e_valid) begin errors++; $display("FAIL rnd_m_tvalid cyc %0d got %0b want %0b", i, m_tvalid, e_valid); end
      checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL rnd_level cyc %0d got %0d want %0d", i, level, q.size()); end
      checks++; if (underflow !== e_uf) begin errors++; $display("FAIL rnd_underflow cyc %0d got %0b want %0b", i, underflow, e_uf); end
      checks++; if (underflow_count !== 16'(e_cnt)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, underflow_count, e_cnt); end
    end
    clear = 0;
  endtask

  task automatic test_async_reset();
    enable = 0; tick();
    enable = 1; m_tready = 1;
    for (int i = 0; i < 30 && st != 2; i++) begin
      s_tvalid = 1; s_tdata = DW'(i + 7);
      tick();
    end
    s_tvalid = 1; tick();
    #2 resetn = 0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || s_tready !== 1'b0 || level !== '0 || underflow !== 1'b0 || underflow_count !== 16'd0)
      begin errors++; $display("FAIL async_reset got v=%0b d=%0h rdy=%0b lvl=%0d uf=%0b cnt=%0d want all 0", m_tvalid, m_tdata, s_tready, level, underflow, underflow_count); end
    model_reset();
    s_tvalid = 0; enable = 0;
    #4 resetn = 1;
  endtask

  initial begin
    test_reset();
    test_prefill_run();
    test_full();
    test_stream();
    test_enable_drop();
    test_underflow_clear();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
